// File: rtl/keypad_pkg.sv
// Shared constants, FSM state encoding and index helpers for the keypad row decoder.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } idx_t;

    // valid is set only for exactly one bit; 0000 and multi-bit patterns are rejected.
    function automatic idx_t onehot_to_idx(input logic [3:0] v);
        idx_t r;
        r.valid = 1'b1;
        r.idx   = 2'd0;
        case (v)
            4'b0001: r.idx = 2'd0;
            4'b0010: r.idx = 2'd1;
            4'b0100: r.idx = 2'd2;
            4'b1000: r.idx = 2'd3;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchroniser bringing asynchronous inputs into the clk domain.
module keypad_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_row_decoder.sv
// Paces the column scan, debounces the synchronised rows and emits one key code per press.
// scan_en is a single-cycle pulse with no ready back-pressure: the ring counter steps on every pulse.
module keypad_row_decoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DWELL      = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_COLS-1:0] col,
    input  logic [NUM_ROWS-1:0] row,
    output logic                scan_en,
    output logic                key_valid,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_down,
    output state_t              dbg_state
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DWELL - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_dwell;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_cand_row;
    logic [1:0]       r_cand_col;
    logic             r_scan_en;
    logic             r_key_valid;
    logic [KEY_W-1:0] r_key_code;
    logic             r_key_down;

    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_dwell_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [1:0]          w_cand_row_nxt;
    logic [1:0]          w_cand_col_nxt;
    logic                w_scan_en_nxt;
    logic                w_key_valid_nxt;
    logic [KEY_W-1:0]    w_key_code_nxt;
    logic                w_key_down_nxt;
    logic [NUM_ROWS-1:0] w_row_s;
    idx_t                w_col_idx;
    logic                w_row_hit;

    keypad_sync2 #(
        .WIDTH (NUM_ROWS)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (row),
        .o_q   (w_row_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_dwell     <= '0;
            r_cnt       <= '0;
            r_cand_row  <= 2'd0;
            r_cand_col  <= 2'd0;
            r_scan_en   <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_key_down  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dwell     <= w_dwell_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cand_row  <= w_cand_row_nxt;
            r_cand_col  <= w_cand_col_nxt;
            r_scan_en   <= w_scan_en_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_down  <= w_key_down_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_dwell_nxt     = r_dwell;
        w_cnt_nxt       = r_cnt;
        w_cand_row_nxt  = r_cand_row;
        w_cand_col_nxt  = r_cand_col;
        w_scan_en_nxt   = 1'b0;
        w_key_valid_nxt = 1'b0;
        w_key_code_nxt  = r_key_code;
        w_key_down_nxt  = r_key_down;
        w_col_idx       = onehot_to_idx(col);
        w_row_hit       = w_row_s[r_cand_row];

        case (r_state)
            IDLE: begin
                if (r_dwell == DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    if (w_row_s != '0 && w_col_idx.valid) begin
                        w_state_nxt    = DEBOUNCE;
                        w_cnt_nxt      = '0;
                        w_cand_row_nxt = lowest_set(w_row_s);
                        w_cand_col_nxt = w_col_idx.idx;
                    end else begin
                        w_scan_en_nxt = 1'b1;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + CNT_ONE;
                end
            end

            DEBOUNCE: begin
                if (w_row_hit) begin
                    if (r_cnt == DEB_LAST) begin
                        w_state_nxt     = WAIT_REL;
                        w_cnt_nxt       = '0;
                        w_key_valid_nxt = 1'b1;
                        w_key_code_nxt  = {r_cand_row, r_cand_col};
                        w_key_down_nxt  = 1'b1;
                    end else if (r_cnt < DEB_LAST) begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end else begin
                    // Bounce: drop the candidate and rescan the same column from a fresh dwell.
                    w_state_nxt = IDLE;
                    w_dwell_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            end

            WAIT_REL: begin
                if (!w_row_hit) begin
                    if (r_cnt == DEB_LAST) begin
                        w_state_nxt    = IDLE;
                        w_dwell_nxt    = '0;
                        w_cnt_nxt      = '0;
                        w_key_down_nxt = 1'b0;
                    end else if (r_cnt < DEB_LAST) begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_dwell_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign scan_en   = r_scan_en;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_down  = r_key_down;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_keypad_row_decoder.sv
// Self-checking bench for keypad_row_decoder with a behavioural ring counter closing the scan loop.
module tb_keypad_row_decoder;
    import keypad_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] col;
    logic [3:0] row;
    logic       scan_en;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_down;
    state_t     dbg_state;

    logic [3:0] ring;
    logic       col_force;
    logic [3:0] col_force_val;

    int n_checks;
    int n_fail;
    int kv_total;
    logic [3:0] exp_q[$];

    keypad_row_decoder #(
        .SCAN_DWELL      (8),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col       (col),
        .row       (row),
        .scan_en   (scan_en),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_down  (key_down),
        .dbg_state (dbg_state)
    );

    // clock / reset / ring counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset)       ring <= 4'b0001;
        else if (scan_en) ring <= {ring[2:0], ring[3]};
    end

    assign col = col_force ? col_force_val : ring;

    // scoreboard: every key_valid pops one expected code
    always @(negedge clk) begin
        if (reset && key_valid) begin
            kv_total++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: key_valid with code %h, required no key_valid", key_code);
            end else begin
                logic [3:0] exp;
                exp = exp_q.pop_front();
                if (key_code !== exp) begin
                    n_fail++;
                    $display("FAIL sb_code: key_code %h, required %h", key_code, exp);
                end
            end
            n_checks++;
            if (key_down !== 1'b1) begin
                n_fail++;
                $display("FAIL sb_key_down: key_down %b with key_valid, required 1", key_down);
            end
        end
    end

    // driver tasks
    task automatic wait_scan(input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < limit && !ok) begin
            @(negedge clk);
            cycles++;
            if (scan_en) ok = 1'b1;
        end
    endtask

    task automatic wait_col(input logic [3:0] target, output bit ok);
        int n;
        n = 0;
        while (col === target && n < 100) begin @(negedge clk); n++; end
        while (col !== target && n < 200) begin @(negedge clk); n++; end
        ok = (col === target);
    endtask

    task automatic press_key(input logic [3:0] tcol, input logic [3:0] trow,
                             input logic [3:0] code, input string name);
        bit ok;
        int lat;
        wait_col(tcol, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_col_wait: col %b, required %b", name, col, tcol);
        end
        row = trow;
        exp_q.push_back(code);
        lat = 0;
        ok = 1'b0;
        while (lat < 40 && !ok) begin
            @(negedge clk);
            lat++;
            if (key_valid) ok = 1'b1;
        end
        n_checks++;
        if (!ok || lat != 11) begin
            n_fail++;
            $display("FAIL %s_latency: key_valid after %0d cycles (seen=%0d), required 11", name, lat, ok);
        end
    endtask

    task automatic release_key(input string name);
        int n;
        row = 4'b0000;
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (!key_down) break;
        end
        n_checks++;
        if (n != 6) begin
            n_fail++;
            $display("FAIL %s_release: key_down fell after %0d cycles, required 6", name, n);
        end
    endtask

    // scenarios
    task automatic test_reset();
        n_checks++;
        if ({scan_en, key_valid, key_code, key_down} !== 7'd0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_values: scan_en=%b key_valid=%b key_code=%h key_down=%b state=%0d, required all 0",
                     scan_en, key_valid, key_code, key_down, dbg_state);
        end
    endtask

    task automatic test_idle_scan();
        int cyc;
        bit ok;
        logic [3:0] exp_col;
        int kv0;
        kv0 = kv_total;
        exp_col = 4'b0001;
        wait_scan(20, cyc, ok);
        n_checks++;
        if (!ok || cyc != 9) begin
            n_fail++;
            $display("FAIL scan_first: first scan_en after %0d cycles (seen=%0d), required 9", cyc, ok);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (col !== exp_col) begin
                n_fail++;
                $display("FAIL scan_col_%0d: col %b, required %b", i, col, exp_col);
            end
            exp_col = {exp_col[2:0], exp_col[3]};
            wait_scan(20, cyc, ok);
            n_checks++;
            if (!ok || cyc != 8) begin
                n_fail++;
                $display("FAIL scan_period_%0d: %0d cycles, required 8", i, cyc);
            end
        end
        n_checks++;
        if (kv_total != kv0) begin
            n_fail++;
            $display("FAIL scan_no_key: %0d key_valid pulses, required 0", kv_total - kv0);
        end
    endtask

    task automatic test_single_press();
        int scans;
        int kv_hi;
        int cyc;
        bit ok;
        press_key(4'b0100, 4'b0010, 4'h6, "press");
        scans = 0;
        kv_hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (scan_en) scans++;
            if (key_valid) kv_hi++;
        end
        n_checks++;
        if (scans != 0 || kv_hi != 0) begin
            n_fail++;
            $display("FAIL press_hold: scan_en pulses %0d, extra key_valid %0d, required 0 and 0", scans, kv_hi);
        end
        n_checks++;
        if (key_down !== 1'b1 || key_code !== 4'h6) begin
            n_fail++;
            $display("FAIL press_held_outputs: key_down=%b key_code=%h, required 1 and 6", key_down, key_code);
        end
        release_key("press");
        wait_scan(20, cyc, ok);
        n_checks++;
        if (!ok || cyc != 8 || col !== 4'b0100) begin
            n_fail++;
            $display("FAIL press_resume: scan_en after %0d cycles on col %b, required 8 on 0100", cyc, col);
        end
        n_checks++;
        if (key_code !== 4'h6) begin
            n_fail++;
            $display("FAIL press_code_hold: key_code %h after release, required 6", key_code);
        end
    endtask

    task automatic test_bounce();
        int kv0;
        int kd_hi;
        int cyc;
        bit ok;
        kv0 = kv_total;
        kd_hi = 0;
        for (int i = 0; i < 30; i++) begin
            row = ((i % 3) < 2) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            if (key_down) kd_hi++;
        end
        row = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (key_down) kd_hi++;
        end
        n_checks++;
        if (kv_total != kv0 || kd_hi != 0) begin
            n_fail++;
            $display("FAIL bounce_no_key: key_valid %0d, key_down cycles %0d, required 0 and 0",
                     kv_total - kv0, kd_hi);
        end
        wait_scan(20, cyc, ok);
        wait_scan(20, cyc, ok);
        n_checks++;
        if (!ok || cyc != 8) begin
            n_fail++;
            $display("FAIL bounce_resume: scan period %0d, required 8", cyc);
        end
    endtask

    task automatic test_multi_row();
        int kv0;
        kv0 = kv_total;
        press_key(4'b0001, 4'b0110, 4'h4, "multi");
        repeat (20) @(negedge clk);
        n_checks++;
        if (kv_total != kv0 + 1) begin
            n_fail++;
            $display("FAIL multi_once: %0d key_valid pulses, required 1", kv_total - kv0);
        end
        release_key("multi");
    endtask

    task automatic test_reset_in_wait_rel();
        int kv0;
        int cyc;
        bit ok;
        press_key(4'b1000, 4'b0001, 4'h3, "rst");
        repeat (3) @(negedge clk);
        n_checks++;
        if (dbg_state !== WAIT_REL) begin
            n_fail++;
            $display("FAIL rst_pre_state: state %0d, required %0d", dbg_state, WAIT_REL);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({scan_en, key_valid, key_code, key_down} !== 7'd0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL rst_async: scan_en=%b key_valid=%b key_code=%h key_down=%b state=%0d, required all 0",
                     scan_en, key_valid, key_code, key_down, dbg_state);
        end
        row = 4'b0000;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        kv0 = kv_total;
        wait_scan(20, cyc, ok);
        n_checks++;
        if (!ok || cyc != 8 || col !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_dwell_restart: scan_en after %0d cycles on col %b, required 8 on 0001", cyc, col);
        end
        repeat (30) @(negedge clk);
        n_checks++;
        if (kv_total != kv0) begin
            n_fail++;
            $display("FAIL rst_spurious: %0d key_valid pulses, required 0", kv_total - kv0);
        end
    endtask

    task automatic test_bad_col();
        int kv0;
        int cyc;
        bit ok;
        logic [3:0] pats [2];
        pats[0] = 4'b0011;
        pats[1] = 4'b0000;
        kv0 = kv_total;
        wait_scan(20, cyc, ok);
        col_force = 1'b1;
        row = 4'b0001;
        for (int p = 0; p < 2; p++) begin
            col_force_val = pats[p];
            for (int i = 0; i < 3; i++) begin
                wait_scan(20, cyc, ok);
                n_checks++;
                if (!ok || cyc != 8) begin
                    n_fail++;
                    $display("FAIL badcol_%b_period_%0d: %0d cycles, required 8", pats[p], i, cyc);
                end
            end
        end
        n_checks++;
        if (kv_total != kv0 || key_down !== 1'b0) begin
            n_fail++;
            $display("FAIL badcol_no_key: key_valid %0d key_down %b, required 0 and 0", kv_total - kv0, key_down);
        end
        row = 4'b0000;
        col_force = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        kv_total = 0;
        reset = 1'b0;
        row = 4'b0000;
        col_force = 1'b0;
        col_force_val = 4'b0000;
        #2;
        test_reset();
        #15 reset = 1'b1;
        test_idle_scan();
        test_single_press();
        test_bounce();
        test_multi_row();
        test_reset_in_wait_rel();
        test_bad_col();
        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected codes never produced, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
